// File: rtl/na_conf_wb_reader_if.sv
// Wishbone B4 classic master bus bundle for na_conf_wb_reader.
//
// master modport: drives address/cycle/strobe and the fixed write-side fields,
//                 receives read data and the ack/rty/err terminations.
// slave modport : the mirror image, for a responder or a testbench model.
interface na_conf_wb_reader_if;
    logic [31:0] wbm_adr_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_rty_i;
    logic        wbm_err_i;

    modport master (
        output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
               wbm_cti_o, wbm_bte_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_rty_i, wbm_err_i
    );

    modport slave (
        input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
               wbm_cti_o, wbm_bte_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_rty_i, wbm_err_i
    );
endinterface

// File: rtl/na_conf_wb_reader.sv
// Reads a burst of 32-bit config words over Wishbone classic single cycles and
// streams them out through a valid/ready port.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              one-cycle request, sampled only when idle
//   start_adr, count   first word index and number of words (count 0 = no-op done)
//   busy               burst in progress
//   done / error       one-cycle completion / abort pulses
//   err_code           abort cause (01 bus err, 10 retries exhausted, 11 timeout)
//   out_data/valid/ready  read word stream
//   wbm                Wishbone master bundle
module na_conf_wb_reader #(
    parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [15:0]                start_adr,
    input  logic [7:0]                 count,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [31:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    na_conf_wb_reader_if.master        wbm
);
    localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {StIdle, StBus, StBackoff, StOut} state_e;

    state_e            state_q;
    logic [15:0]       word_idx_q;
    logic [7:0]        remaining_q;
    logic [RetryW-1:0] retry_cnt_q;
    logic [15:0]       tmo_cnt_q;
    logic              cyc_q;
    logic [31:0]       adr_q;

    logic [15:0]       next_idx;
    logic [15:0]       tmo_inc;
    logic              bus_abort;
    logic [1:0]        abort_code;

    // Byte address of a word index; wraps modulo 2^32.
    function automatic logic [31:0] word_adr(input logic [15:0] idx);
        return BASE_ADR + {14'd0, idx, 2'b00};
    endfunction

    assign next_idx = word_idx_q + 16'd1;
    assign tmo_inc  = tmo_cnt_q + 16'd1;

    // Abort decision for the current BUS cycle; err outranks ack, ack outranks rty.
    always_comb begin
        bus_abort  = 1'b0;
        abort_code = 2'b00;
        if (wbm.wbm_err_i) begin
            bus_abort  = 1'b1;
            abort_code = 2'b01;
        end else if (wbm.wbm_ack_i) begin
            bus_abort  = 1'b0;
        end else if (wbm.wbm_rty_i) begin
            if (retry_cnt_q == RetryW'(MAX_RETRY)) begin
                bus_abort  = 1'b1;
                abort_code = 2'b10;
            end
        end else if (tmo_inc == 16'(TIMEOUT)) begin
            bus_abort  = 1'b1;
            abort_code = 2'b11;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            word_idx_q  <= '0;
            remaining_q <= '0;
            retry_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            cyc_q       <= 1'b0;
            adr_q       <= BASE_ADR;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'b00;
            out_data    <= '0;
            out_valid   <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        err_code <= 2'b00;
                        if (count == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            word_idx_q  <= start_adr;
                            remaining_q <= count;
                            retry_cnt_q <= '0;
                            tmo_cnt_q   <= '0;
                            adr_q       <= word_adr(start_adr);
                            cyc_q       <= 1'b1;
                            busy        <= 1'b1;
                            state_q     <= StBus;
                        end
                    end
                end
                StBus: begin
                    if (bus_abort) begin
                        cyc_q    <= 1'b0;
                        error    <= 1'b1;
                        err_code <= abort_code;
                        busy     <= 1'b0;
                        state_q  <= StIdle;
                    end else if (wbm.wbm_ack_i) begin
                        out_data  <= wbm.wbm_dat_i;
                        out_valid <= 1'b1;
                        cyc_q     <= 1'b0;
                        state_q   <= StOut;
                    end else if (wbm.wbm_rty_i) begin
                        // Each re-issue gets a fresh timeout window.
                        retry_cnt_q <= retry_cnt_q + 1'b1;
                        tmo_cnt_q   <= '0;
                        cyc_q       <= 1'b0;
                        state_q     <= StBackoff;
                    end else begin
                        tmo_cnt_q <= tmo_inc;
                    end
                end
                StBackoff: begin
                    cyc_q   <= 1'b1;
                    state_q <= StBus;
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (remaining_q == 8'd1) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            remaining_q <= remaining_q - 8'd1;
                            word_idx_q  <= next_idx;
                            adr_q       <= word_adr(next_idx);
                            retry_cnt_q <= '0;
                            tmo_cnt_q   <= '0;
                            cyc_q       <= 1'b1;
                            state_q     <= StBus;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = 1'b0;
    assign wbm.wbm_sel_o = 4'hf;
    assign wbm.wbm_cti_o = 3'b000;
    assign wbm.wbm_bte_o = 2'b00;
    assign wbm.wbm_dat_o = 32'd0;
endmodule

// File: tb/tb_na_conf_wb_reader.sv
// Self-checking bench for na_conf_wb_reader: a scripted Wishbone slave, a
// random-backpressure consumer and a burst-level reference model.
module tb_na_conf_wb_reader;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int          MAXR = 3;
    localparam int          TMO  = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_adr = '0;
    logic [7:0]  count = '0;
    logic        busy, done, error, out_valid;
    logic [1:0]  err_code;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;

    na_conf_wb_reader_if wb ();

    na_conf_wb_reader #(
        .BASE_ADR (BASE),
        .MAX_RETRY(MAXR),
        .TIMEOUT  (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .start_adr(start_adr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .wbm      (wb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave configuration and logs.
    bit          hang;
    int          ws;
    int          rty_plan[256];
    int          err_word;
    bit          err_with_ack;
    bit          noise;
    bit [31:0]   salt;
    int          beat_no, rty_used, wait_cnt, cur_len, gap_len, last_len;
    logic        cyc_prev = 1'b0;
    logic [31:0] adr_log[$];
    int          gap_log[$];
    int          ready_pct = 100;

    // Monitor logs.
    int          done_cnt, err_cnt;
    bit          busy_seen;
    logic        busy_prev = 1'b0;
    logic        done_busy_now, done_busy_prev;
    logic [31:0] got_q[$];

    // Reference-model results.
    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    int          exp_done;
    logic [1:0]  exp_code;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    initial begin
        wb.wbm_ack_i = 1'b0;
        wb.wbm_rty_i = 1'b0;
        wb.wbm_err_i = 1'b0;
        wb.wbm_dat_i = '0;
    end

    // Wishbone slave: responds after ws wait states following its plan.
    always @(posedge clk) begin
        #1;
        wb.wbm_ack_i = 1'b0;
        wb.wbm_rty_i = 1'b0;
        wb.wbm_err_i = 1'b0;
        wb.wbm_dat_i = $urandom;
        if (wb.wbm_cyc_o) begin
            if (!cyc_prev) begin
                adr_log.push_back(wb.wbm_adr_o);
                gap_log.push_back(gap_len);
                wait_cnt = 0;
                cur_len  = 1;
            end else begin
                wait_cnt++;
                cur_len++;
            end
            if (!hang && wait_cnt == ws) begin
                if (beat_no == err_word) begin
                    wb.wbm_err_i = 1'b1;
                    wb.wbm_ack_i = err_with_ack;
                    wb.wbm_rty_i = 1'($urandom_range(0, 1));
                end else if (rty_used < rty_plan[beat_no]) begin
                    wb.wbm_rty_i = 1'b1;
                    rty_used++;
                end else begin
                    wb.wbm_ack_i = 1'b1;
                    wb.wbm_dat_i = mem(wb.wbm_adr_o);
                    beat_no++;
                    rty_used = 0;
                end
            end
            gap_len = 0;
        end else begin
            if (cyc_prev) last_len = cur_len;
            gap_len++;
            if (noise) begin
                wb.wbm_ack_i = ($urandom_range(0, 3) == 0);
                wb.wbm_rty_i = ($urandom_range(0, 3) == 0);
                wb.wbm_err_i = ($urandom_range(0, 3) == 0);
            end
        end
        cyc_prev = wb.wbm_cyc_o;
    end

    always @(posedge clk) begin
        #1;
        out_ready = ($urandom_range(0, 99) < ready_pct);
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_busy_now  = busy;
            done_busy_prev = busy_prev;
        end
        if (error) err_cnt++;
        if (busy) busy_seen = 1'b1;
        if (out_valid && out_ready) got_q.push_back(out_data);
        busy_prev = busy;
    end

    task automatic clear_log();
        adr_log.delete();
        gap_log.delete();
        got_q.delete();
        done_cnt     = 0;
        err_cnt      = 0;
        busy_seen    = 1'b0;
        beat_no      = 0;
        rty_used     = 0;
        hang         = 1'b0;
        err_word     = -1;
        err_with_ack = 1'b0;
        noise        = 1'b0;
        ws           = 1;
        last_len     = 0;
        ready_pct    = 100;
        salt         = $urandom;
        for (int i = 0; i < 256; i++) rty_plan[i] = 0;
    endtask

    // Burst-level model: which addresses get bus cycles, which words come out,
    // and how the burst ends.
    task automatic model(input logic [15:0] sa, input int cnt);
        logic [31:0] a;
        exp_adr_q.delete();
        exp_dat_q.delete();
        exp_done = 0;
        exp_code = 2'b00;
        for (int i = 0; i < cnt; i++) begin
            a = BASE + 32'((int'(sa) + i) % 65536) * 32'd4;
            if (i == err_word) begin
                exp_adr_q.push_back(a);
                exp_code = 2'b01;
                return;
            end
            if (rty_plan[i] > MAXR) begin
                for (int r = 0; r <= MAXR; r++) exp_adr_q.push_back(a);
                exp_code = 2'b10;
                return;
            end
            for (int r = 0; r <= rty_plan[i]; r++) exp_adr_q.push_back(a);
            exp_dat_q.push_back(mem(a));
        end
        exp_done = 1;
    endtask

    task automatic run_burst(input logic [15:0] sa, input logic [7:0] cnt, input int budget,
                             output bit finished);
        @(posedge clk); #1;
        start = 1'b1; start_adr = sa; count = cnt;
        @(posedge clk); #1;
        start = 1'b0; start_adr = 16'($urandom); count = 8'($urandom);
        finished = 1'b0;
        for (int i = 0; i < budget && !finished; i++) begin
            @(negedge clk);
            if (done_cnt + err_cnt > 0) finished = 1'b1;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, error, err_code, out_valid} !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000", {busy, done, error, err_code, out_valid});
        end
        n_cmp++;
        if ({wb.wbm_cyc_o, wb.wbm_stb_o, out_data} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_cyc_data: got cyc=%b stb=%b data=%h want 0", wb.wbm_cyc_o,
                     wb.wbm_stb_o, out_data);
        end
        n_cmp++;
        if (wb.wbm_adr_o !== BASE) begin
            n_bad++;
            $display("FAIL reset_adr: got %h want %h", wb.wbm_adr_o, BASE);
        end
        n_cmp++;
        if ({wb.wbm_we_o, wb.wbm_sel_o, wb.wbm_cti_o, wb.wbm_bte_o, wb.wbm_dat_o} !==
            {1'b0, 4'hf, 3'b000, 2'b00, 32'd0}) begin
            n_bad++;
            $display("FAIL tie_offs: got we=%b sel=%h cti=%b bte=%b dat=%h want 0 f 000 00 0",
                     wb.wbm_we_o, wb.wbm_sel_o, wb.wbm_cti_o, wb.wbm_bte_o, wb.wbm_dat_o);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_burst();
        bit fin;
        clear_log();
        run_burst(16'h0004, 8'd3, 200, fin);
        n_cmp++;
        if (fin !== 1'b1) begin n_bad++; $display("FAIL basic_finish: got 0 want 1"); end
        n_cmp++;
        if (adr_log.size() != 3 || adr_log[0] !== BASE + 32'h10 || adr_log[1] !== BASE + 32'h14 ||
            adr_log[2] !== BASE + 32'h18) begin
            n_bad++;
            $display("FAIL basic_adr: got %p want %h %h %h", adr_log, BASE + 32'h10,
                     BASE + 32'h14, BASE + 32'h18);
        end
        n_cmp++;
        if (got_q.size() != 3 || got_q[0] !== mem(BASE + 32'h10) ||
            got_q[1] !== mem(BASE + 32'h14) || got_q[2] !== mem(BASE + 32'h18)) begin
            n_bad++;
            $display("FAIL basic_data: got %p want 3 words from 0x10..0x18", got_q);
        end
        n_cmp++;
        if (done_cnt != 1 || err_cnt != 0 || err_code !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_done: got done=%0d err=%0d code=%b want 1 0 00", done_cnt,
                     err_cnt, err_code);
        end
        n_cmp++;
        if (done_busy_prev !== 1'b1 || done_busy_now !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_busy_fall: got busy before/at done %b%b want 10", done_busy_prev,
                     done_busy_now);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] sa;
        logic [31:0] held;
        bit          stable;
        bit          fin;
        clear_log();
        ready_pct = 0;
        ws = 0;
        sa = 16'($urandom);
        @(posedge clk); #1;
        start = 1'b1; start_adr = sa; count = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        held   = out_data;
        stable = out_valid;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== held) stable = 1'b0;
            // A start while busy must not launch anything.
            start = (i == 3); start_adr = 16'h1234; count = 8'd5;
        end
        start = 1'b0;
        n_cmp++;
        if (stable !== 1'b1 || held !== mem(BASE + {14'd0, sa, 2'b00})) begin
            n_bad++;
            $display("FAIL hold_stable: got stable=%b data=%h want 1 %h", stable, held,
                     mem(BASE + {14'd0, sa, 2'b00}));
        end
        n_cmp++;
        if (done_cnt != 0 || adr_log.size() != 1) begin
            n_bad++;
            $display("FAIL hold_no_progress: got done=%0d cycles=%0d want 0 1", done_cnt,
                     adr_log.size());
        end
        ready_pct = 100;
        fin = 1'b0;
        for (int i = 0; i < 20 && !fin; i++) begin
            @(negedge clk);
            if (done_cnt > 0) fin = 1'b1;
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (fin !== 1'b1 || done_cnt != 1 || got_q.size() != 1 || adr_log.size() != 1) begin
            n_bad++;
            $display("FAIL hold_accept: got fin=%b done=%0d words=%0d cycles=%0d want 1 1 1 1",
                     fin, done_cnt, got_q.size(), adr_log.size());
        end
    endtask

    task automatic test_retry_ok();
        bit fin;
        clear_log();
        rty_plan[0] = 3;
        run_burst(16'h0100, 8'd1, 200, fin);
        n_cmp++;
        if (adr_log.size() != 4 || gap_log.size() != 4 ||
            adr_log[0] !== BASE + 32'h400 || adr_log[3] !== BASE + 32'h400 ||
            gap_log[1] != 1 || gap_log[2] != 1 || gap_log[3] != 1) begin
            n_bad++;
            $display("FAIL retry_cycles: got adr=%p gaps=%p want 4x %h gaps 1", adr_log, gap_log,
                     BASE + 32'h400);
        end
        n_cmp++;
        if (fin !== 1'b1 || done_cnt != 1 || err_cnt != 0 || got_q.size() != 1 ||
            got_q[0] !== mem(BASE + 32'h400)) begin
            n_bad++;
            $display("FAIL retry_success: got done=%0d err=%0d words=%0d want 1 0 1", done_cnt,
                     err_cnt, got_q.size());
        end
    endtask

    task automatic test_retry_exhausted();
        bit fin;
        clear_log();
        rty_plan[0] = 4;
        run_burst(16'h0100, 8'd2, 200, fin);
        n_cmp++;
        if (fin !== 1'b1 || err_cnt != 1 || done_cnt != 0 || err_code !== 2'b10) begin
            n_bad++;
            $display("FAIL retry_abort: got err=%0d done=%0d code=%b want 1 0 10", err_cnt,
                     done_cnt, err_code);
        end
        n_cmp++;
        if (adr_log.size() != 4 || got_q.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL retry_abort_state: got cycles=%0d words=%0d busy=%b valid=%b want 4 0 0 0",
                     adr_log.size(), got_q.size(), busy, out_valid);
        end
    endtask

    task automatic test_timeout();
        bit fin;
        clear_log();
        hang = 1'b1;
        run_burst(16'h0020, 8'd2, 400, fin);
        n_cmp++;
        if (fin !== 1'b1 || err_cnt != 1 || done_cnt != 0 || err_code !== 2'b11) begin
            n_bad++;
            $display("FAIL timeout_abort: got err=%0d done=%0d code=%b want 1 0 11", err_cnt,
                     done_cnt, err_code);
        end
        n_cmp++;
        if (last_len != TMO || adr_log.size() != 1 || wb.wbm_cyc_o !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_len: got cyc_len=%0d cycles=%0d want %0d 1", last_len,
                     adr_log.size(), TMO);
        end
    endtask

    task automatic test_err_with_ack();
        bit fin;
        clear_log();
        err_word = 1;
        err_with_ack = 1'b1;
        run_burst(16'h0040, 8'd4, 200, fin);
        n_cmp++;
        if (fin !== 1'b1 || err_cnt != 1 || done_cnt != 0 || err_code !== 2'b01) begin
            n_bad++;
            $display("FAIL errack_abort: got err=%0d done=%0d code=%b want 1 0 01", err_cnt,
                     done_cnt, err_code);
        end
        n_cmp++;
        if (got_q.size() != 1 || adr_log.size() != 2 || got_q[0] !== mem(BASE + 32'h100)) begin
            n_bad++;
            $display("FAIL errack_words: got words=%0d cycles=%0d want 1 2", got_q.size(),
                     adr_log.size());
        end
    endtask

    task automatic test_wrap();
        bit fin;
        clear_log();
        run_burst(16'hFFFF, 8'd2, 200, fin);
        n_cmp++;
        if (adr_log.size() != 2 || adr_log[0] !== BASE + 32'h3FFFC || adr_log[1] !== BASE) begin
            n_bad++;
            $display("FAIL wrap_adr: got %p want %h %h", adr_log, BASE + 32'h3FFFC, BASE);
        end
        n_cmp++;
        if (fin !== 1'b1 || done_cnt != 1 || got_q.size() != 2) begin
            n_bad++;
            $display("FAIL wrap_done: got done=%0d words=%0d want 1 2", done_cnt, got_q.size());
        end
    endtask

    task automatic test_zero_count();
        bit fin;
        clear_log();
        run_burst(16'h0007, 8'd0, 10, fin);
        n_cmp++;
        if (fin !== 1'b1 || done_cnt != 1 || err_cnt != 0 || adr_log.size() != 0 ||
            busy_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_count: got done=%0d err=%0d cycles=%0d busy_seen=%b want 1 0 0 0",
                     done_cnt, err_cnt, adr_log.size(), busy_seen);
        end
    endtask

    task automatic test_reset_mid_burst();
        clear_log();
        hang = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; start_adr = 16'h0050; count = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !wb.wbm_cyc_o; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({wb.wbm_cyc_o, wb.wbm_stb_o, busy, done, error, err_code, out_valid} !== 8'd0 ||
            out_data !== 32'd0 || wb.wbm_adr_o !== BASE || adr_log.size() != 1) begin
            n_bad++;
            $display("FAIL midreset_async: got cyc=%b stb=%b busy=%b valid=%b adr=%h cycles=%0d want 0 0 0 0 %h 1",
                     wb.wbm_cyc_o, wb.wbm_stb_o, busy, out_valid, wb.wbm_adr_o, adr_log.size(), BASE);
        end
        hang = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (done_cnt != 0 || err_cnt != 0 || wb.wbm_cyc_o !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_quiet: got done=%0d err=%0d cyc=%b busy=%b want 0 0 0 0",
                     done_cnt, err_cnt, wb.wbm_cyc_o, busy);
        end
    endtask

    task automatic test_random_bursts();
        bit          fin;
        bit          ok;
        logic [15:0] sa;
        int          cnt;
        for (int t = 0; t < 30; t++) begin
            clear_log();
            noise = 1'b1;
            ws = $urandom_range(0, 2);
            ready_pct = $urandom_range(30, 100);
            sa = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65530, 65535)) : 16'($urandom);
            cnt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            for (int i = 0; i < cnt; i++) begin
                rty_plan[i] = ($urandom_range(0, 9) == 0) ? MAXR + 1 : $urandom_range(0, MAXR);
            end
            if ($urandom_range(0, 6) == 0 && cnt > 0) err_word = $urandom_range(0, cnt - 1);
            err_with_ack = 1'($urandom_range(0, 1));
            model(sa, cnt);
            run_burst(sa, 8'(cnt), 600, fin);
            ok = (adr_log.size() == exp_adr_q.size());
            foreach (exp_adr_q[i]) if (i < adr_log.size() && adr_log[i] !== exp_adr_q[i]) ok = 1'b0;
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL rand%0d_adr: got %p want %p", t, adr_log, exp_adr_q);
            end
            ok = (got_q.size() == exp_dat_q.size());
            foreach (exp_dat_q[i]) if (i < got_q.size() && got_q[i] !== exp_dat_q[i]) ok = 1'b0;
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL rand%0d_data: got %p want %p", t, got_q, exp_dat_q);
            end
            n_cmp++;
            if (fin !== 1'b1 || done_cnt != exp_done || err_cnt != 1 - exp_done ||
                err_code !== exp_code || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rand%0d_end: got fin=%b done=%0d err=%0d code=%b busy=%b want 1 %0d %0d %b 0",
                         t, fin, done_cnt, err_cnt, err_code, busy, exp_done, 1 - exp_done, exp_code);
            end
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_retry_ok();
        test_retry_exhausted();
        test_timeout();
        test_err_with_ack();
        test_wrap();
        test_zero_count();
        test_reset_mid_burst();
        test_random_bursts();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
